tick_timer: RTL and testbench

Programmable down-counting timer that consumes the clk_divider output as a data signal, never as a clock. It synchronizes and edge-detects that slow square wave into one-cycle ticks in the system clk domain. It counts a loaded number of ticks and pulses expired in one-shot or periodic mode. It sits directly downstream of clk_divider and provides timeouts and periodic events to control logic.

---
 rtl/tick_timer.sv | 154 +++++++++++++++
 tb/tb_tick_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// tick_timer: programmable down-counting timer driven by synchronized
// ticks taken from a slow square wave (clk_divider output) used as data.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   clk_div_in in   slow square wave, sampled as data
//   start      in   one-cycle request: load load_val, latch mode, run
//   stop       in   one-cycle request: abort the run
//   mode       in   0 = one-shot, 1 = periodic (sampled on start)
//   load_val   in   tick count (sampled on start)
//   tick       out  one-clk pulse per synchronized rising edge
//   busy       out  high while running
//   count      out  ticks remaining in the current period
//   expired    out  one-clk pulse when the count reaches terminal
module tick_timer #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div_in,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_tick;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_reload;
    logic                   r_mode;
    logic                   r_expired;

    state_t                 w_nxt_state;
    logic [CNT_W-1:0]       w_nxt_count;
    logic [CNT_W-1:0]       w_nxt_reload;
    logic                   w_nxt_mode;
    logic                   w_nxt_expired;

    logic                   w_sync_last;
    logic                   w_load_zero;
    logic                   w_terminal;

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_load_zero = (load_val == '0);
    assign w_terminal  = (r_count == CNT_W'(1));

    // Synchronizer and rising-edge detector. prev resets to 0 so an
    // input already high when reset releases still yields one tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clk_div_in};
            r_prev <= w_sync_last;
            r_tick <= w_sync_last & ~r_prev;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_mode    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_count   <= w_nxt_count;
            r_reload  <= w_nxt_reload;
            r_mode    <= w_nxt_mode;
            r_expired <= w_nxt_expired;
        end
    end

    // Event priority in RUN is stop > start > tick. A start always
    // discards the current run, so a coincident terminal tick is lost.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_count   = r_count;
        w_nxt_reload  = r_reload;
        w_nxt_mode    = r_mode;
        w_nxt_expired = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_load_zero) begin
                        w_nxt_expired = 1'b1;
                    end else begin
                        w_nxt_state  = RUN;
                        w_nxt_count  = load_val;
                        w_nxt_reload = load_val;
                        w_nxt_mode   = mode;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    w_nxt_state = IDLE;
                    w_nxt_count = '0;
                end else if (start) begin
                    if (w_load_zero) begin
                        w_nxt_state   = IDLE;
                        w_nxt_count   = '0;
                        w_nxt_expired = 1'b1;
                    end else begin
                        w_nxt_count  = load_val;
                        w_nxt_reload = load_val;
                        w_nxt_mode   = mode;
                    end
                end else if (r_tick) begin
                    if (w_terminal) begin
                        w_nxt_expired = 1'b1;
                        if (r_mode) begin
                            w_nxt_count = r_reload;
                        end else begin
                            w_nxt_count = '0;
                            w_nxt_state = IDLE;
                        end
                    end else if (r_count != '0) begin
                        w_nxt_count = r_count - CNT_W'(1);
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_count = '0;
            end
        endcase
    end

    assign tick    = r_tick;
    assign busy    = (r_state == RUN);
    assign count   = r_count;
    assign expired = r_expired;

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: directed, table-driven bench for tick_timer.
// Inputs change on the falling edge; outputs are checked there too.
module tb_tick_timer;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             clk_div_in;
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] load_val;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             expired;

    int checks;
    int failures;

    tick_timer #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_div_in(clk_div_in),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .load_val  (load_val),
        .tick      (tick),
        .busy      (busy),
        .count     (count),
        .expired   (expired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic             din;
        logic             st;
        logic             sp;
        logic             md;
        logic [CNT_W-1:0] ld;
        logic             tk;
        logic             bz;
        logic [CNT_W-1:0] ct;
        logic             ex;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic din, input logic st, input logic sp,
        input logic md, input int ld,
        input logic tk, input logic bz, input int ct, input logic ex
    );
        vec_t v;
        v.din = din; v.st = st; v.sp = sp; v.md = md;
        v.ld = CNT_W'(ld);
        v.tk = tk; v.bz = bz; v.ct = CNT_W'(ct); v.ex = ex;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic din, input logic st, input logic sp,
                         input logic md, input int ld);
        clk_div_in = din;
        start      = st;
        stop       = sp;
        mode       = md;
        load_val   = CNT_W'(ld);
    endtask

    // apply inputs, cross one rising edge, come back to the falling edge
    task automatic step(input logic din, input logic st, input logic sp,
                        input logic md, input int ld);
        drive(din, st, sp, md, ld);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string nm, input logic tk, input logic bz,
                           input int ct, input logic ex);
        chk({nm, ".tick"},    int'(tick),    int'(tk));
        chk({nm, ".busy"},    int'(busy),    int'(bz));
        chk({nm, ".count"},   int'(count),   ct);
        chk({nm, ".expired"}, int'(expired), int'(ex));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // din | start stop mode load || tick busy count expired
        // one-shot, load 3
        tbl.push_back(mk(0,1,0,0,3, 0,1,3,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,3,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,3,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,3,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,2,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,2,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,2,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        // periodic, load 2, six ticks, then stop
        tbl.push_back(mk(0,1,0,1,2, 0,1,2,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,2,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,2,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,2,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,2,1));
        tbl.push_back(mk(0,0,0,0,0, 0,1,2,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,2,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,2,1));
        tbl.push_back(mk(0,0,0,0,0, 0,1,2,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,2,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,2,1));
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        // stop together with a terminal tick
        tbl.push_back(mk(0,1,0,0,1, 0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,0));
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        // start load 5 together with a terminal tick
        tbl.push_back(mk(0,1,0,0,1, 0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,0));
        tbl.push_back(mk(0,1,0,0,5, 0,1,5,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,5,0));
        // zero-length start from RUN and from IDLE
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        // stop in IDLE ignored; start+stop in RUN -> IDLE
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0,4, 0,1,4,0));
        tbl.push_back(mk(0,1,1,1,7, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));

        // reset held for 5 clocks
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk_all("reset", 1'b0, 1'b0, 0, 1'b0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].din, tbl[i].st, tbl[i].sp, tbl[i].md,
                 int'(tbl[i].ld));
            chk_all($sformatf("v%0d", i), tbl[i].tk, tbl[i].bz,
                    int'(tbl[i].ct), tbl[i].ex);
        end

        // level held high 10 clocks then dropped: one tick only
        for (int j = 0; j < 13; j++) begin
            step(j < 10, 1'b0, 1'b0, 1'b0, 0);
            chk($sformatf("level%0d.tick", j), int'(tick), int'(j == 2));
        end

        // asynchronous reset in the middle of a run
        step(1'b0, 1'b1, 1'b0, 1'b0, 9);
        chk_all("run9", 1'b0, 1'b1, 9, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 0, 1'b0);

        // input high through reset and after release
        @(negedge clk);
        clk_div_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hi.tick", int'(tick), 0);
        rst = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 0);
            chk($sformatf("rel%0d.tick", j), int'(tick), int'(j == 3));
        end
        chk("rel.busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
